// File: rtl/compare_pkg.sv
// -----------------------------------------------------------------------------
// compare_pkg
//   Shared definitions for the sequential magnitude comparator family.
//   - state_t  : FSM state encoding (IDLE / RUN).
//   - RES_*    : bit positions of the one-hot result vector {GT, EQ, LT}.
//   - clog2()  : ceiling log2, used to size the slice index register.
// -----------------------------------------------------------------------------
package compare_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // One-hot result vector layout: {GT, EQ, LT}
   localparam int RES_W  = 3;
   localparam int RES_GT = 2;
   localparam int RES_EQ = 1;
   localparam int RES_LT = 0;

   typedef logic [RES_W-1:0] res_t;

   localparam res_t RES_NONE = 3'b000;

   // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Build a one-hot result from the three compare flags.
   function automatic res_t res_pack(input logic gt, input logic eq, input logic lt);
      res_t r;
      r         = RES_NONE;
      r[RES_GT] = gt;
      r[RES_EQ] = eq;
      r[RES_LT] = lt;
      return r;
   endfunction

endpackage

// File: rtl/compare_digit.sv
// -----------------------------------------------------------------------------
// compare_digit
//   Purely combinational unsigned comparator for one DIGIT-bit slice.
//   Ports:
//     A, B  : slice operands (unsigned)
//     GT    : A > B
//     EQ    : A == B
//     LT    : A < B
//   Exactly one of GT/EQ/LT is high for any input pair.
// -----------------------------------------------------------------------------
module compare_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] A,
   input  logic [DIGIT-1:0] B,
   output logic             GT,
   output logic             EQ,
   output logic             LT
);

   logic w_eq;
   logic w_gt;

   assign w_eq = (A == B);
   assign w_gt = (A > B);

   assign EQ = w_eq;
   assign GT = w_gt;
   assign LT = ~w_eq & ~w_gt;

endmodule

// File: rtl/compare_seq_nbit.sv
// -----------------------------------------------------------------------------
// compare_seq_nbit
//   Multi-cycle magnitude comparator. Compares two WIDTH-bit operands one
//   DIGIT-bit slice per cycle, MSB slice first, and finishes at the first
//   slice that differs (or after the last slice when all are equal).
//   Signed compares are mapped onto unsigned ones by flipping the sign bit of
//   both operands when they are latched.
//
//   Ports:
//     CLK     : clock, all state changes on the rising edge
//     RST     : synchronous active-high reset, highest priority
//     START   : request a compare (accepted only while BUSY = 0)
//     SIGNED  : 1 = two's-complement compare, 0 = unsigned (sampled with START)
//     A, B    : operands (sampled with START)
//     BUSY    : compare in progress
//     DONE    : one-cycle pulse, new result on GT/EQ/LT
//     GT/EQ/LT: registered result, held until the next DONE or RST
//
//   Timing: START in cycle 0 -> BUSY in cycles 1..k -> DONE in cycle k+1,
//   where k (1..NDIG) is the number of slices examined.
// -----------------------------------------------------------------------------
module compare_seq_nbit
   import compare_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SIGNED,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic             GT,
   output logic             EQ,
   output logic             LT
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int IDXW = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);

   localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NDIG - 1);
   localparam logic [IDXW-1:0]  IDX_ONE  = IDXW'(1);
   localparam logic [WIDTH-1:0] SIGN_MSK = WIDTH'(1) << (WIDTH - 1);

   if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_err
      $error("compare_seq_nbit: DIGIT must divide WIDTH and lie in 1..WIDTH");
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t           r_state;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [IDXW-1:0]  r_idx;
   logic             r_done;
   res_t             r_res;

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] w_flip;
   logic [DIGIT-1:0] w_slice_a;
   logic [DIGIT-1:0] w_slice_b;
   logic             w_gt;
   logic             w_eq;
   logic             w_lt;
   logic             w_last;

   // Flipping the sign bit of both operands turns two's-complement order into
   // plain unsigned order, so the slice comparator never needs a signed mode.
   assign w_flip = SIGN_MSK & {WIDTH{SIGNED}};

   // Slice selector: explicit mux over the constant slice positions keeps the
   // index arithmetic out of the part-select.
   always_comb begin
      w_slice_a = '0;
      w_slice_b = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (r_idx == IDXW'(i)) begin
            w_slice_a = r_opa[i*DIGIT +: DIGIT];
            w_slice_b = r_opb[i*DIGIT +: DIGIT];
         end
      end
   end

   assign w_last = (r_idx == '0);

   compare_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .A  (w_slice_a),
      .B  (w_slice_b),
      .GT (w_gt),
      .EQ (w_eq),
      .LT (w_lt)
   );

   // ---------------------------------------------------------------------------
   // FSM, operand/index registers and result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_opa   <= '0;
         r_opb   <= '0;
         r_idx   <= '0;
         r_done  <= 1'b0;
         r_res   <= RES_NONE;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // The result registers are left alone here so the previous
               // result stays visible while the new compare runs.
               if (START) begin
                  r_opa   <= A ^ w_flip;
                  r_opb   <= B ^ w_flip;
                  r_idx   <= IDX_TOP;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!w_eq) begin
                  // First differing slice decides the whole compare.
                  r_res   <= res_pack(w_gt, 1'b0, w_lt);
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (w_last) begin
                  r_res   <= res_pack(1'b0, 1'b1, 1'b0);
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_idx <= r_idx - IDX_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign BUSY = (r_state == ST_RUN);
   assign DONE = r_done;
   assign GT   = r_res[RES_GT];
   assign EQ   = r_res[RES_EQ];
   assign LT   = r_res[RES_LT];

endmodule

// File: tb/tb_compare_seq_nbit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// Testbench for compare_seq_nbit. Three instances share one stimulus bus:
//   inst 0 : WIDTH=16, DIGIT=4
//   inst 1 : WIDTH=8,  DIGIT=8  (low byte of the bus)
//   inst 2 : WIDTH=16, DIGIT=1
// The stimulus process decides per instance whether a START is accepted and
// pushes the expected response; the monitor pops and compares at negedge.
// -----------------------------------------------------------------------------
module tb_compare_seq_nbit;

   localparam int NI = 3;

   typedef struct {
      int         st;    // cycle in which START was accepted
      int         dn;    // cycle in which DONE must be high
      logic [2:0] res;   // {GT, EQ, LT}
   } exp_t;

   typedef struct {
      int         cyc;
      int         inst;
      logic [4:0] v;     // {BUSY, DONE, GT, EQ, LT}
      string      nm;
   } dchk_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sgn = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;

   logic [NI-1:0] w_busy, w_done, w_gt, w_eq, w_lt;

   int     cyc = 0;
   int     c_now = 0;
   bit     chk_en = 1'b0;
   int     n_cmp = 0;
   int     n_bad = 0;

   exp_t       q[NI][$];
   dchk_t      dq[$];
   logic [2:0] held[NI];
   int         m_st[NI];
   int         m_dn[NI];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   compare_seq_nbit #(.WIDTH(16), .DIGIT(4)) u_d0 (
      .CLK(clk), .RST(rst), .START(start), .SIGNED(sgn), .A(a), .B(b),
      .BUSY(w_busy[0]), .DONE(w_done[0]), .GT(w_gt[0]), .EQ(w_eq[0]), .LT(w_lt[0]));

   compare_seq_nbit #(.WIDTH(8), .DIGIT(8)) u_d1 (
      .CLK(clk), .RST(rst), .START(start), .SIGNED(sgn), .A(a[7:0]), .B(b[7:0]),
      .BUSY(w_busy[1]), .DONE(w_done[1]), .GT(w_gt[1]), .EQ(w_eq[1]), .LT(w_lt[1]));

   compare_seq_nbit #(.WIDTH(16), .DIGIT(1)) u_d2 (
      .CLK(clk), .RST(rst), .START(start), .SIGNED(sgn), .A(a), .B(b),
      .BUSY(w_busy[2]), .DONE(w_done[2]), .GT(w_gt[2]), .EQ(w_eq[2]), .LT(w_lt[2]));

   function automatic int cfg_w(input int i);
      return (i == 1) ? 8 : 16;
   endfunction

   function automatic int cfg_d(input int i);
      return (i == 0) ? 4 : ((i == 1) ? 8 : 1);
   endfunction

   // Reference: numeric compare of the operands as integers, latency from the
   // position of the most significant differing bit.
   function automatic exp_t model(input int i, input logic [15:0] va, input logic [15:0] vb,
                                  input logic vs, input int c);
      exp_t        e;
      int          w, d, hi, k;
      longint      xa, xb;
      logic [15:0] x;
      w  = cfg_w(i);
      d  = cfg_d(i);
      xa = longint'(va) & ((longint'(1) << w) - 1);
      xb = longint'(vb) & ((longint'(1) << w) - 1);
      if (vs && xa >= (longint'(1) << (w - 1))) xa = xa - (longint'(1) << w);
      if (vs && xb >= (longint'(1) << (w - 1))) xb = xb - (longint'(1) << w);
      e.res = (xa > xb) ? 3'b100 : ((xa == xb) ? 3'b010 : 3'b001);
      x  = va ^ vb;
      hi = -1;
      for (int j = 0; j < w; j++) if (x[j]) hi = j;
      k = (hi < 0) ? (w / d) : ((w / d) - (hi / d));
      e.st = c;
      e.dn = c + k + 1;
      return e;
   endfunction

   task automatic check(input string nm, input int inst, input logic [4:0] act, input logic [4:0] want);
      n_cmp = n_cmp + 1;
      if (act !== want) begin
         n_bad = n_bad + 1;
         $display("FAIL %s inst%0d cycle %0d: got %b required %b", nm, inst, cyc, act, want);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic       eb, ed;
      logic [4:0] obs;
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            eb = 1'b0;
            ed = 1'b0;
            if (q[i].size() > 0) begin
               if (q[i][0].st < cyc && cyc < q[i][0].dn) eb = 1'b1;
               if (q[i][0].dn == cyc) begin
                  ed      = 1'b1;
                  held[i] = q[i][0].res;
               end
            end
            check("busy",   i, {4'b0, w_busy[i]}, {4'b0, eb});
            check("done",   i, {4'b0, w_done[i]}, {4'b0, ed});
            check("result", i, {2'b0, w_gt[i], w_eq[i], w_lt[i]}, {2'b0, held[i]});
            if (ed) void'(q[i].pop_front());
         end
         for (int j = dq.size() - 1; j >= 0; j--) begin
            if (dq[j].cyc == cyc) begin
               obs = {w_busy[dq[j].inst], w_done[dq[j].inst], w_gt[dq[j].inst],
                      w_eq[dq[j].inst], w_lt[dq[j].inst]};
               check(dq[j].nm, dq[j].inst, obs, dq[j].v);
               dq.delete(j);
            end
         end
      end
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            q[i].delete();
            held[i] = 3'b000;
         end
      end
   end

   // One clock cycle of stimulus, driven just after the rising edge.
   task automatic step(input logic st, input logic [15:0] va, input logic [15:0] vb,
                       input logic vs, input logic vr);
      exp_t e;
      @(posedge clk);
      #1;
      start = st; a = va; b = vb; sgn = vs; rst = vr;
      c_now = cyc;
      for (int i = 0; i < NI; i++) begin
         if (vr) begin
            m_st[i] = 0;
            m_dn[i] = 0;
         end else if (st && !(c_now > m_st[i] && c_now < m_dn[i])) begin
            e = model(i, va, vb, vs, c_now);
            m_st[i] = e.st;
            m_dn[i] = e.dn;
            q[i].push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, a, b, sgn, 1'b0);
   endtask

   task automatic idle_rand(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic post(input int c, input int inst, input logic [4:0] v, input string nm);
      dchk_t d;
      d.cyc = c; d.inst = inst; d.v = v; d.nm = nm;
      dq.push_back(d);
   endtask

   initial begin
      int          c0;
      logic [15:0] ra, rb;
      for (int i = 0; i < NI; i++) begin
         held[i] = 3'b000;
         m_st[i] = 0;
         m_dn[i] = 0;
      end

      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      chk_en = 1'b1;
      post(c_now, 0, 5'b00000, "reset_state");
      post(c_now, 2, 5'b00000, "reset_state");
      idle(2);

      // Equal operands: all four slices examined
      step(1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0);
      c0 = c_now;
      post(c0 + 1, 0, 5'b10000, "eq_busy_c1");
      post(c0 + 4, 0, 5'b10000, "eq_busy_c4");
      post(c0 + 5, 0, 5'b01010, "eq_done_c5");
      idle(18);

      // Early exit at MSB slice, unsigned then signed
      step(1'b1, 16'h9000, 16'h1FFF, 1'b0, 1'b0);
      c0 = c_now;
      post(c0 + 1, 0, 5'b10010, "ugt_busy_prev_eq");
      post(c0 + 2, 0, 5'b01100, "ugt_done_c2");
      idle(18);
      step(1'b1, 16'h9000, 16'h1FFF, 1'b1, 1'b0);
      c0 = c_now;
      post(c0 + 2, 0, 5'b01001, "slt_done_c2");
      idle(18);

      // Low-slice difference, then result held while inputs toggle
      step(1'b1, 16'h00A1, 16'h00A3, 1'b0, 1'b0);
      c0 = c_now;
      post(c0 + 5, 0, 5'b01001, "lt_done_c5");
      post(c0 + 15, 0, 5'b00001, "lt_held");
      idle_rand(18);

      // START while busy is ignored
      step(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
      c0 = c_now;
      idle(1);
      step(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
      step(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
      post(c0 + 5, 0, 5'b01010, "ign_eq_done_c5");
      post(c0 + 6, 0, 5'b00010, "ign_no_second_done");
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      idle(18);

      // RST mid-compare aborts
      step(1'b1, 16'h1234, 16'h1235, 1'b0, 1'b0);
      c0 = c_now;
      idle(2);
      step(1'b0, a, b, sgn, 1'b1);
      post(c0 + 4, 0, 5'b00000, "rst_abort");
      post(c0 + 4, 2, 5'b00000, "rst_abort");
      post(c0 + 5, 0, 5'b00000, "rst_no_done");
      idle(18);

      // Back-to-back: new START in the DONE cycle
      step(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
      c0 = c_now;
      idle(4);
      step(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
      post(c0 + 5, 0, 5'b01010, "b2b_first_done");
      post(c0 + 6, 0, 5'b10010, "b2b_eq_held");
      post(c0 + 7, 0, 5'b01001, "b2b_lt_done");
      idle(18);

      // Bit-serial instance: all sixteen slices, and single-slice instance
      step(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0);
      c0 = c_now;
      post(c0 + 2, 1, 5'b01001, "w8_lt_done_c2");
      post(c0 + 17, 2, 5'b01001, "d1_lt_done_c17");
      idle(18);

      // Randomized traffic with random gaps (some STARTs land while busy)
      for (int n = 0; n < 200; n++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
            2:       rb = {ra[15:8], 8'($urandom)};
            default: rb = 16'($urandom);
         endcase
         step(1'b1, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
         idle_rand($urandom_range(0, 18));
      end
      idle(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/compare_seq_nbit.md
Name: compare_seq_nbit

Overview:
Parametrised, multi-cycle magnitude comparator. It is the generalised successor of the fixed 4-bit GT/EQ/LT comparator. It compares two WIDTH-bit operands one DIGIT-bit slice per cycle, starting at the MSB slice, and stops early at the first slice that differs. It adds a signed/unsigned mode and a START/BUSY/DONE handshake, and holds its registered result for downstream logic (sorter, threshold checks on the LaunchPad datapath).

Parameters:
WIDTH, 16, operand width in bits; WIDTH % DIGIT == 0 required.
DIGIT, 4, bits compared per cycle; 1 <= DIGIT <= WIDTH.
(derived) NDIG = WIDTH/DIGIT, number of slices; IDXW = max(1, clog2(NDIG)).

Ports:
CLK  input  1  clock. All state changes on the rising edge.
RST  input  1  synchronous, active-high reset.
START  input  1  request a compare. Accepted only when BUSY=0.
SIGNED  input  1  1 = two's-complement compare, 0 = unsigned. Sampled with START.
A  input  WIDTH  operand A. Sampled with START.
B  input  WIDTH  operand B. Sampled with START.
BUSY  output  1  compare in progress.
DONE  output  1  one-cycle pulse: new result valid.
GT  output  1  A > B (registered, held).
EQ  output  1  A == B (registered, held).
LT  output  1  A < B (registered, held).

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state=IDLE, BUSY=0, DONE=0, GT=0, EQ=0, LT=0; index and operand registers cleared.
- RST has priority over all other inputs. RST mid-compare aborts the compare: no DONE, and the outputs go to reset values on the next cycle.
- FSM states: IDLE, RUN.
- IDLE → RUN when START=1 at the clock edge.
  - Latch opA = A ^ (SIGNED<<(WIDTH-1)) and opB = B ^ (SIGNED<<(WIDTH-1)). This sign-bit flip maps signed order onto unsigned order.
  - Set idx = NDIG-1.
- RUN: combinational slice compare of opA[idx*DIGIT +: DIGIT] against opB[same slice].
  - Slices differ: register GT/LT from that slice, EQ=0, pulse DONE, go to IDLE.
  - Slices equal and idx==0: register EQ=1, GT=0, LT=0, pulse DONE, go to IDLE.
  - Slices equal and idx>0: idx decrements, stay in RUN.
- BUSY = (state==RUN).
- Timing: START high in cycle 0 gives BUSY high in cycles 1..k and DONE high in cycle k+1.
  - k = number of slices examined, 1..NDIG.
  - Minimum latency 2 cycles, maximum NDIG+1.
- GT/EQ/LT update only at the DONE edge. They hold until the next DONE or RST and are not cleared when a new START is accepted. Exactly one of GT/EQ/LT is 1 after the first DONE.
- START while BUSY=1 is ignored: no queuing, and A/B/SIGNED changes have no effect.
- START in the DONE cycle is accepted, because the FSM is already in IDLE. Back-to-back throughput is k+1 cycles per compare.
- NDIG=1 (DIGIT=WIDTH): single RUN cycle, latency always 2.
- Operands are latched, so A/B may change freely after acceptance.

Decomposition:
- Shared package compare_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
  - function clog2.
  - result encoding constants (RES_GT/EQ/LT one-hot order).
- One natural sub-module: compare_digit, a purely combinational DIGIT-bit comparator (inputs A,B; outputs GT,EQ,LT), parametrised by DIGIT. It is instanced once in RUN to compare the selected slice.
- Top level holds the FSM, the operand and index registers, and the result registers.

Test Plan:
- WIDTH=16, DIGIT=4, unsigned, A=0x1234, B=0x1234: BUSY cycles 1–4, DONE in cycle 5, EQ=1, GT=LT=0.
- A=0x9000, B=0x1FFF: SIGNED=0 gives GT=1 with DONE in cycle 2 (early exit at MSB slice); SIGNED=1 gives LT=1, also DONE in cycle 2.
- A=0x00A1, B=0x00A3, unsigned: DONE in cycle 5, LT=1. Results then held over 10 idle cycles while A/B toggle randomly.
- START asserted in cycles 2–3 during a busy compare (A=0x0001, B=0x0001): ignored, single DONE in cycle 5, EQ=1. RST in cycle 3 of a second compare: no DONE, BUSY=0 and GT=EQ=LT=0 next cycle.
- Back-to-back: second START in the DONE cycle with A=0x8000, B=0x7FFF, SIGNED=1. Accepted, LT=1, DONE two cycles later. Previous EQ=1 held until then.
- Parameter sweep with randomized A/B/SIGNED checked against a reference compare:
  - WIDTH=8, DIGIT=8: latency always 2.
  - WIDTH=16, DIGIT=1: A=0x0000, B=0x0001 gives DONE in cycle 17, LT=1.
